// File: rtl/alu_issue.sv
// ---------------------------------------------------------------------------
// alu_issue: single-entry issue register between RV32I register read and the
// ALU. Decodes the integer ALU subset (R-type, I-type ALU, LUI, AUIPC) into an
// ALU opcode plus two operands and holds the result for the downstream stage
// under a valid/ready handshake.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   in_valid / in_ready upstream handshake (in_ready is combinational)
//   instr, pc           instruction word and its address
//   rs1_data, rs2_data  register-file read data
//   flush               drop the held entry and any input this cycle
//   out_valid/out_ready downstream handshake
//   ALUop, op1, op2     ALU operation and operands
//   rd, rd_we           destination register and writeback enable
//   illegal             (only with ALU_ISSUE_ILLEGAL_EN) entry was not a
//                       recognised ALU encoding
//
// Build option: define ALU_ISSUE_ILLEGAL_EN to add the illegal output.
// Parameter SUPPRESS_X0: force rd_we low when rd is x0.
// ---------------------------------------------------------------------------
module alu_issue #(
   parameter bit SUPPRESS_X0 = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] instr,
   input  logic [31:0] pc,
   input  logic [31:0] rs1_data,
   input  logic [31:0] rs2_data,
   input  logic        flush,
   input  logic        out_ready,
   output logic        out_valid,
   output logic [3:0]  ALUop,
   output logic [31:0] op1,
   output logic [31:0] op2,
   output logic [4:0]  rd,
`ifdef ALU_ISSUE_ILLEGAL_EN
   output logic        illegal,
`endif
   output logic        rd_we
);

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_SUB = 4'b0001;
   localparam logic [3:0] OP_AND = 4'b0010;
   localparam logic [3:0] OP_OR  = 4'b0011;
   localparam logic [3:0] OP_XOR = 4'b0100;
   localparam logic [3:0] OP_SLL = 4'b0101;
   localparam logic [3:0] OP_SRL = 4'b0110;
   localparam logic [3:0] OP_SRA = 4'b0111;
   localparam logic [3:0] OP_SLT = 4'b1000;

   localparam logic [6:0] OPC_R     = 7'b0110011;
   localparam logic [6:0] OPC_I     = 7'b0010011;
   localparam logic [6:0] OPC_LUI   = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC = 7'b0010111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   logic [6:0]  opcode;
   logic [2:0]  f3;
   logic [6:0]  f7;
   logic [31:0] imm_i, imm_u, shamt;

   assign opcode = instr[6:0];
   assign f3     = instr[14:12];
   assign f7     = instr[31:25];
   assign imm_i  = {{20{instr[31]}}, instr[31:20]};
   assign imm_u  = {instr[31:12], 12'b0};
   assign shamt  = {27'b0, instr[24:20]};

   logic        valid_q;
   logic [3:0]  aluop_q, aluop_d;
   logic [31:0] op1_q, op1_d, op2_q, op2_d;
   logic [4:0]  rd_q;
   logic        we_q, we_d;
   logic        ill_q, ill_d;
   logic        capture;

   // Decode of the current inputs
   always_comb begin
      ill_d   = 1'b0;
      aluop_d = OP_ADD;
      op1_d   = rs1_data;
      op2_d   = rs2_data;
      unique case (opcode)
         OPC_R: begin
            unique case (f3)
               3'b000: begin
                  if (f7 == F7_BASE)     aluop_d = OP_ADD;
                  else if (f7 == F7_ALT) aluop_d = OP_SUB;
                  else                   ill_d   = 1'b1;
               end
               3'b101: begin
                  if (f7 == F7_BASE)     aluop_d = OP_SRL;
                  else if (f7 == F7_ALT) aluop_d = OP_SRA;
                  else                   ill_d   = 1'b1;
               end
               3'b001: begin aluop_d = OP_SLL; ill_d = (f7 != F7_BASE); end
               3'b010: begin aluop_d = OP_SLT; ill_d = (f7 != F7_BASE); end
               3'b100: begin aluop_d = OP_XOR; ill_d = (f7 != F7_BASE); end
               3'b110: begin aluop_d = OP_OR;  ill_d = (f7 != F7_BASE); end
               3'b111: begin aluop_d = OP_AND; ill_d = (f7 != F7_BASE); end
               default: ill_d = 1'b1;       // 011 (SLTU) is not issued here
            endcase
         end
         OPC_I: begin
            op2_d = imm_i;
            unique case (f3)
               3'b000: aluop_d = OP_ADD;
               3'b010: aluop_d = OP_SLT;
               3'b100: aluop_d = OP_XOR;
               3'b110: aluop_d = OP_OR;
               3'b111: aluop_d = OP_AND;
               3'b001: begin
                  op2_d   = shamt;
                  aluop_d = OP_SLL;
                  ill_d   = (f7 != F7_BASE);
               end
               3'b101: begin
                  op2_d = shamt;
                  if (f7 == F7_BASE)     aluop_d = OP_SRL;
                  else if (f7 == F7_ALT) aluop_d = OP_SRA;
                  else                   ill_d   = 1'b1;
               end
               default: ill_d = 1'b1;
            endcase
         end
         OPC_LUI: begin
            op1_d = '0;
            op2_d = imm_u;
         end
         OPC_AUIPC: begin
            op1_d = pc;
            op2_d = imm_u;
         end
         default: ill_d = 1'b1;
      endcase

      // Illegal entries still flow through, but as a harmless no-write ADD
      if (ill_d) begin
         aluop_d = OP_ADD;
         op1_d   = '0;
         op2_d   = '0;
      end
      we_d = !ill_d && !(SUPPRESS_X0 && (instr[11:7] == 5'd0));
   end

   assign in_ready = !valid_q || out_ready;
   assign capture  = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         aluop_q <= OP_ADD;
         op1_q   <= '0;
         op2_q   <= '0;
         rd_q    <= '0;
         we_q    <= 1'b0;
         ill_q   <= 1'b0;
      end else if (flush) begin
         valid_q <= 1'b0;
      end else if (capture) begin
         valid_q <= 1'b1;
         aluop_q <= aluop_d;
         op1_q   <= op1_d;
         op2_q   <= op2_d;
         rd_q    <= instr[11:7];
         we_q    <= we_d;
         ill_q   <= ill_d;
      end else if (out_ready) begin
         valid_q <= 1'b0;
      end
   end

   assign out_valid = valid_q;
   assign ALUop     = aluop_q;
   assign op1       = op1_q;
   assign op2       = op2_q;
   assign rd        = rd_q;
   assign rd_we     = we_q;

`ifdef ALU_ISSUE_ILLEGAL_EN
   assign illegal = ill_q;
`else
   logic unused_ill;
   assign unused_ill = ill_q;
`endif

endmodule

// File: tb/tb_alu_issue.sv
module tb_alu_issue;

   logic        clk = 1'b0;
   logic        rst, in_valid, in_ready, flush, out_ready, out_valid, rd_we;
   logic [31:0] instr, pc, rs1_data, rs2_data, op1, op2;
   logic [3:0]  ALUop;
   logic [4:0]  rd;
`ifdef ALU_ISSUE_ILLEGAL_EN
   logic        illegal;
`endif

   always #5 clk = ~clk;

   alu_issue #(.SUPPRESS_X0(1'b1)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .instr(instr), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
      .flush(flush), .out_ready(out_ready), .out_valid(out_valid),
      .ALUop(ALUop), .op1(op1), .op2(op2), .rd(rd),
`ifdef ALU_ISSUE_ILLEGAL_EN
      .illegal(illegal),
`endif
      .rd_we(rd_we)
   );

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a, b;
      logic [4:0]  rd;
      logic        we, ill;
   } exp_t;

   exp_t q[$];
   int   nvec = 0, nerr = 0;
   bit   started = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference: ALU op per funct3 for the base (f7=0) encodings
   function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pcv,
                                  input logic [31:0] r1, input logic [31:0] r2);
      exp_t e;
      logic [3:0] optab [8];
      logic [2:0] f3;
      logic [6:0] f7;
      bit ok;
      optab = '{4'd0, 4'd5, 4'd8, 4'd0, 4'd4, 4'd6, 4'd3, 4'd2};
      f3 = ins[14:12];
      f7 = ins[31:25];
      ok = 0;
      e.op = 4'd0; e.a = r1; e.b = r2; e.rd = ins[11:7];
      case (ins[6:0])
         7'h33: begin
            if (f3 != 3'd3 && f7 == 7'h00) begin ok = 1; e.op = optab[f3]; end
            else if (f7 == 7'h20 && f3 == 3'd0) begin ok = 1; e.op = 4'd1; end
            else if (f7 == 7'h20 && f3 == 3'd5) begin ok = 1; e.op = 4'd7; end
         end
         7'h13: begin
            e.b = 32'($signed(ins[31:20]));
            if (f3 == 3'd1 || f3 == 3'd5) begin
               e.b = 32'(ins[24:20]);
               if (f7 == 7'h00) begin ok = 1; e.op = optab[f3]; end
               else if (f7 == 7'h20 && f3 == 3'd5) begin ok = 1; e.op = 4'd7; end
            end else if (f3 != 3'd3) begin
               ok = 1; e.op = optab[f3];
            end
         end
         7'h37: begin ok = 1; e.a = 0;   e.b = ins & 32'hFFFFF000; end
         7'h17: begin ok = 1; e.a = pcv; e.b = ins & 32'hFFFFF000; end
         default: ok = 0;
      endcase
      if (!ok) begin e.op = 0; e.a = 0; e.b = 0; end
      e.ill = !ok;
      e.we  = ok && (e.rd != 0);
      return e;
   endfunction

   // Drive one cycle; update the expected-entry queue at the clock edge
   task automatic cyc(input logic v, input logic [31:0] ins, input logic [31:0] p,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic ordy, input logic fl, input logic r);
      in_valid = v; instr = ins; pc = p; rs1_data = a; rs2_data = b;
      out_ready = ordy; flush = fl; rst = r;
      @(posedge clk);
      if (r) begin q.delete(); started = 1; end
      else if (fl) begin if (q.size() > 0) void'(q.pop_front()); end
      else if (v && q.size() == 0) q.push_back(model(ins, p, a, b));
      #1;
   endtask

   task automatic chk_zero(input string nm);
      @(negedge clk);
      chk({nm, ".valid"}, 32'(out_valid), 0);
      chk({nm, ".op"},    32'(ALUop), 0);
      chk({nm, ".op1"},   op1, 0);
      chk({nm, ".op2"},   op2, 0);
      chk({nm, ".rd"},    32'(rd), 0);
      chk({nm, ".we"},    32'(rd_we), 0);
`ifdef ALU_ISSUE_ILLEGAL_EN
      chk({nm, ".ill"},   32'(illegal), 0);
`endif
      @(posedge clk); #1;
   endtask

   // Monitor: presence, ready, and contents of the held entry every cycle;
   // pops when the downstream handshake completes.
   always @(negedge clk) begin
      if (started && !rst) begin
         chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
         chk("in_ready", 32'(in_ready), 32'(q.size() == 0 || out_ready));
         if (out_valid && q.size() != 0) begin
            chk("ALUop", 32'(ALUop), 32'(q[0].op));
            chk("op1",   op1, q[0].a);
            chk("op2",   op2, q[0].b);
            chk("rd",    32'(rd), 32'(q[0].rd));
            chk("rd_we", 32'(rd_we), 32'(q[0].we));
`ifdef ALU_ISSUE_ILLEGAL_EN
            chk("illegal", 32'(illegal), 32'(q[0].ill));
`endif
            if (out_ready) void'(q.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] ins;
      logic [6:0]  opcs [5];
      opcs = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03};

      cyc(0, 0, 0, 0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 0, 0, 1);
      chk_zero("reset");

      // Directed encodings from the requirements
      cyc(1, 32'h002081B3, 0, 5, 7, 1, 0, 0);          // add x3,x1,x2
      cyc(1, 32'hFFF0A093, 0, 3, 0, 1, 0, 0);          // slti x1,x1,-1
      cyc(1, 32'h4050D093, 0, 32'h80000000, 0, 1, 0, 0); // srai x1,x1,5
      cyc(1, 32'h0020B1B3, 0, 9, 9, 1, 0, 0);          // sltu -> illegal
      cyc(1, 32'h00000037, 0, 9, 9, 1, 0, 0);          // lui x0
      cyc(1, 32'h12345197, 32'h100, 1, 2, 1, 0, 0);    // auipc x3
      cyc(0, 0, 0, 0, 0, 1, 0, 0);

      // Stall: sub captured, then three cycles of back-pressure
      cyc(1, 32'h402081B3, 0, 10, 4, 1, 0, 0);
      repeat (3) cyc(1, 32'h00520233, 0, 11, 22, 0, 0, 0);
      cyc(1, 32'h00520233, 0, 11, 22, 1, 0, 0);
      cyc(0, 0, 0, 0, 0, 1, 0, 0);

      // Flush with a held entry and a simultaneous new input
      cyc(1, 32'h002081B3, 0, 1, 1, 0, 0, 0);
      cyc(1, 32'h00A00093, 0, 1, 1, 0, 1, 0);
      cyc(0, 0, 0, 0, 0, 1, 0, 0);

      // Reset while stalled
      cyc(1, 32'h0020F1B3, 0, 6, 3, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0);
      cyc(1, 32'h00A00093, 0, 1, 1, 0, 0, 1);
      chk_zero("rst_stall");

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         logic v, ordy, fl;
         int  k;
         ins = $urandom;
         ins[6:0] = opcs[$urandom_range(0, 4)];
         k = $urandom_range(0, 3);
         if (k == 0) ins[31:25] = 7'h00;
         else if (k == 1) ins[31:25] = 7'h20;
         if ($urandom_range(0, 7) == 0) ins[11:7] = 0;
         v    = ($urandom_range(0, 3) != 0);
         ordy = ($urandom_range(0, 2) != 0);
         fl   = ($urandom_range(0, 19) == 0);
         if (fl) ordy = 0;
         cyc(v, ins, $urandom, $urandom, $urandom, ordy, fl, 0);
      end

      repeat (3) cyc(0, 0, 0, 0, 0, 1, 0, 0);
      chk("drain", 32'(q.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 Parameter SUPPRESS_X0, default 1: when 1, rd_we is forced 0 for any instruction whose rd field is 0.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  instr/pc/rs1_data/rs2_data valid this cycle.
REQ-005 in_ready  output  1  block accepts input this cycle.
REQ-006 instr  input  32  RV32I instruction word.
REQ-007 pc  input  32  address of instr.
REQ-008 rs1_data, rs2_data  input  32 each  register-file read data.
REQ-009 flush  input  1  discard held entry.
REQ-010 out_ready  input  1  downstream ALU stage consumes the entry.
REQ-011 out_valid  output  1  registered entry present.
REQ-012 ALUop  output  4  ALU operation code: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLL 0101, SRL 0110, SRA 0111, SLT 1000.
REQ-013 op1, op2  output  32 each  ALU operands.
REQ-014 rd  output  5  destination register; rd_we output 1 writeback enable.

Function
REQ-015 Single-entry pipeline register; in_ready = !out_valid || out_ready (combinational).
REQ-016 Capture when in_valid && in_ready: all outputs register the decode of the current inputs; out_valid=1 next cycle; latency exactly 1 cycle.
REQ-017 out_valid && out_ready && !(in_valid && in_ready): out_valid=0 next cycle.
REQ-018 out_valid && !out_ready: all outputs hold unchanged (no change to ALUop/op1/op2/rd/rd_we while stalled).
REQ-019 flush has priority over capture: out_valid=0 next cycle, input in same cycle dropped.
REQ-020 R-type (opcode 0110011), op1=rs1_data, op2=rs2_data: f3 000/f7 0000000 ADD; 000/0100000 SUB; 111 AND; 110 OR; 100 XOR; 001 SLL; 101/0000000 SRL; 101/0100000 SRA; 010 SLT; rd_we=1.
REQ-021 I-type (opcode 0010011), op1=rs1_data, op2=sign-extended instr[31:20]: f3 000 ADD, 111 AND, 110 OR, 100 XOR, 010 SLT; 001 (instr[31:25]=0) SLL; 101 with instr[31:25] 0000000 SRL, 0100000 SRA; shift op2 = zero-extended instr[24:20]; rd_we=1.
REQ-022 LUI (0110111): ALUop ADD, op1=0, op2={instr[31:12],12'b0}; AUIPC (0010111): ALUop ADD, op1=pc, same op2; rd_we=1.
REQ-023 Any other encoding (incl. f3 011, bad f7, other opcodes) is illegal: ALUop ADD, op1=op2=0, rd_we=0, still accepted and presented with out_valid=1.
REQ-024 rd = instr[11:7] for all encodings; SUPPRESS_X0 applied after REQ-020..023.

Reset
REQ-025 rst=1 at clock edge: out_valid=0, ALUop=0000, op1=op2=0, rd=0, rd_we=0, illegal=0; overrides capture and flush; in_ready=1 the cycle after rst deasserts.
REQ-026 rst mid-stall discards the held entry; no entry emitted.

Configuration
REQ-027 Macro ALU_ISSUE_ILLEGAL_EN defined: extra output port illegal (1 bit), registered with the entry, 1 exactly for encodings per REQ-023, held during stall, 0 on reset.
REQ-028 Macro undefined: no illegal port; behaviour otherwise identical (REQ-023 still applies).

Verification
REQ-029 Reset then instr 0x002081B3 (add x3,x1,x2), rs1=5, rs2=7, out_ready=1 -> next cycle out_valid=1, ALUop 0000, op1=5, op2=7, rd=3, rd_we=1.
REQ-030 instr 0xFFF0A093 (slti x1,x1,-1), rs1=3 -> ALUop 1000, op2=0xFFFFFFFF; instr 0x4050D093 (srai x1,x1,5) -> ALUop 0111, op2=5.
REQ-031 Stall: out_ready=0 three cycles after capture of sub, new in_valid presented -> in_ready=0, outputs unchanged; out_ready=1 -> new entry captured same cycle, visible next cycle.
REQ-032 flush and in_valid same cycle with held entry -> out_valid=0 next cycle, input lost; rst asserted while stalled -> out_valid=0, all outputs 0.
REQ-033 instr 0x0020B1B3 (sltu) with ALU_ISSUE_ILLEGAL_EN -> illegal=1, rd_we=0, op1=op2=0; instr 0x00000037 (lui x0) with SUPPRESS_X0=1 -> rd_we=0, illegal=0.
REQ-034 AUIPC 0x12345197, pc=0x100 -> ALUop 0000, op1=0x100, op2=0x12345000, rd=3.
